aq_djpeg_mcu_seq: RTL and testbench
===================================

// Module: aq_djpeg_mcu_seq
// PURPOSE
//  Parametrised MCU block sequencer and position tracker for the JPEG decoder.
//  Sits between the IDCT output stage and the colour-space converter.
//  For every finished 8x8 block it works out the block's component, its sub-block position and its MCU X/Y.
//  It queues these as tags in a small FIFO with a valid/ready handshake.
//  Compared with the fixed 3-component 4:4:4/4:2:2/4:2:0 sequencer, it adds:
//   - 1..MAX_COMP components, with sampling factors up to MAX_SAMP;
//   - frame-end detection;
//   - downstream backpressure;
//   - overrun flagging.
// PARAMETERS
//  MAX_COMP   4   maximum component count accepted (1..4)
//  MAX_SAMP   2   maximum H/V sampling factor of component 0 (1..3)
//  XW         12  width of MCU X/Y counters and of McuWidth/McuHeight
//  TAG_DEPTH  4   tag FIFO depth, power of 2, >=2
// PORTS
//  clk           in   1   clock, all logic on rising edge
//  rst           in   1   synchronous active-low reset
//  ProcessInit   in   1   1-cycle frame start: latches config, clears state
//  JpegComp      in   3   component count
//  SubSamplingW  in   2   horizontal sampling factor of component 0
//  SubSamplingH  in   2   vertical sampling factor of component 0
//  McuWidth      in   XW  MCUs per row
//  McuHeight     in   XW  MCU rows per frame
//  BlockDone     in   1   pulse: decoder finished one 8x8 block
//  BlockReady    out  1   tag FIFO can accept a block (count < TAG_DEPTH)
//  TagValid      out  1   tag FIFO head valid
//  TagReady      in   1   converter accepts head tag
//  TagComp       out  2   component index of head block
//  TagSubX       out  2   horizontal sub-block index within component 0
//  TagSubY       out  2   vertical sub-block index within component 0
//  TagMcuX       out  XW  MCU column
//  TagMcuY       out  XW  MCU row
//  TagLast       out  1   head is the last block of its MCU
//  TagFrameEnd   out  1   head is the last block of the frame
//  FrameDone     out  1   level: FrameEnd tag popped; held until ProcessInit/reset
//  BlockOverrun  out  1   sticky: BlockDone arrived when it could not be accepted
// BEHAVIOUR
//  - Reset: FIFO empty, counters 0, state RUN.
//    Output reset values: BlockReady=1, TagValid=0, all Tag* fields=0, FrameDone=0, BlockOverrun=0.
//  - ProcessInit has the same effect as reset, except that it also latches the configuration.
//    Configuration is only sampled at ProcessInit.
//  - Config clamping:
//    - JpegComp: 0 -> 1; >MAX_COMP -> MAX_COMP.
//    - SubSampling*: 0 -> 1; >MAX_SAMP -> MAX_SAMP.
//    - McuWidth/McuHeight: 0 -> 1.
//    - If the latched JpegComp is 1, H=V=1 regardless of the inputs.
//  - MCU block order:
//    - Component 0 first, H*V blocks, SubY outer, SubX inner.
//    - Then components 1..N-1, one block each, with SubX=SubY=0.
//  - Accept condition: BlockDone && BlockReady && state==RUN.
//    - On accept, the tag built from the current counters is pushed.
//    - The counters then advance in the order SubX, SubY, Comp, McuX, McuY.
//    - TagLast=1 on the final block of an MCU.
//    - TagFrameEnd=1 when TagLast is set and McuX==W-1 and McuY==H-1; the state then moves RUN->DONE.
//  - BlockDone with BlockReady=0, or BlockDone in state DONE:
//    - the block is dropped, BlockOverrun<=1, counters unchanged.
//  - FIFO: push on accept, pop on TagValid&&TagReady.
//    - Latency: BlockDone into an empty FIFO -> TagValid=1 on the next cycle.
//    - Simultaneous push and pop: both happen, count unchanged.
//    - When full, a pop does not enable a same-cycle push; BlockReady is registered from count.
//    - Tag fields hold stable while TagValid && !TagReady.
//  - FrameDone<=1 in the cycle after the FrameEnd tag is popped.
//  - The counters wrap only via McuX/McuY rollover; McuY never exceeds H-1 because of the DONE state.
// TESTING
//  - 3 comps, W=2, H=2, McuWidth=2, McuHeight=1, TagReady=1, 12 BlockDone:
//    - comp/sub sequence per MCU: (0,0,0)(0,1,0)(0,0,1)(0,1,1)(1,0,0)(2,0,0);
//    - TagLast on tags 6 and 12; McuX 0 then 1; TagFrameEnd on tag 12; FrameDone=1 after that tag pops.
//  - JpegComp=1, SubSampling 2/2, McuWidth=3, McuHeight=2: 6 tags, all comp0 sub(0,0) with TagLast=1;
//    McuX 0,1,2,0,1,2 and McuY 0,0,0,1,1,1.
//  - TAG_DEPTH=4, TagReady=0, 5 BlockDone:
//    - BlockReady=0 after the 4th;
//    - 5th is dropped with BlockOverrun=1;
//    - TagReady=1 then drains 4 tags in order, BlockReady returns to 1.
//  - FIFO holding 2 tags, BlockDone and pop in the same cycle:
//    - count stays 2; the popped tag is the older one; the new tag appears after the existing one.
//  - ProcessInit after 3 blocks of a 4:2:0 frame:
//    - next cycle TagValid=0, BlockOverrun=0;
//    - the next BlockDone yields comp0, sub(0,0), Mcu(0,0).
//  - Frame done, then an extra BlockDone -> no tag pushed, BlockOverrun=1, FrameDone stays 1;
//    rst=0 for 1 cycle -> all outputs at their reset values.

Source files
------------

// File: rtl/aq_djpeg_mcu_seq.sv
// MCU block sequencer: tags each finished 8x8 block with component, sub-block and MCU X/Y.
// Latency: accepted BlockDone -> tag visible at FIFO head on the next cycle (when FIFO was empty).
// Backpressure: TagReady stalls the tag FIFO; BlockReady drops when full; refused blocks set BlockOverrun.
module aq_djpeg_mcu_seq #(
  parameter int MAX_COMP  = 4,
  parameter int MAX_SAMP  = 2,
  parameter int XW        = 12,
  parameter int TAG_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ProcessInit,
  input  logic [2:0]    JpegComp,
  input  logic [1:0]    SubSamplingW,
  input  logic [1:0]    SubSamplingH,
  input  logic [XW-1:0] McuWidth,
  input  logic [XW-1:0] McuHeight,
  input  logic          BlockDone,
  output logic          BlockReady,
  output logic          TagValid,
  input  logic          TagReady,
  output logic [1:0]    TagComp,
  output logic [1:0]    TagSubX,
  output logic [1:0]    TagSubY,
  output logic [XW-1:0] TagMcuX,
  output logic [XW-1:0] TagMcuY,
  output logic          TagLast,
  output logic          TagFrameEnd,
  output logic          FrameDone,
  output logic          BlockOverrun
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(TAG_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [XW-1:0] XW_ONE   = XW'(1);
  localparam logic [2:0]    MAXC_C   = 3'(MAX_COMP);
  localparam logic [1:0]    MAXS_C   = 2'(MAX_SAMP);

  typedef struct packed {
    logic [1:0]    comp;
    logic [1:0]    subx;
    logic [1:0]    suby;
    logic [XW-1:0] mcux;
    logic [XW-1:0] mcuy;
    logic          last;
    logic          fend;
  } tag_t;

  typedef enum logic {ST_RUN = 1'b0, ST_DONE = 1'b1} state_t;

  // Latched configuration
  logic [2:0]    r_ncomp;
  logic [1:0]    r_h;
  logic [1:0]    r_v;
  logic [XW-1:0] r_mw;
  logic [XW-1:0] r_mh;

  // Position counters and frame state
  state_t        r_state;
  logic [1:0]    r_comp;
  logic [1:0]    r_subx;
  logic [1:0]    r_suby;
  logic [XW-1:0] r_mcux;
  logic [XW-1:0] r_mcuy;

  // Tag FIFO
  tag_t          r_mem [TAG_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_block_ready;

  // Status flags
  logic          r_frame_done;
  logic          r_overrun;

  // Clamped configuration inputs
  logic [2:0]    w_ncomp;
  logic [1:0]    w_h;
  logic [1:0]    w_v;
  logic [XW-1:0] w_mw;
  logic [XW-1:0] w_mh;

  logic          w_sub_end;
  logic          w_comp_last;
  logic          w_blk_last;
  logic          w_mx_end;
  logic          w_my_end;
  logic          w_frame_end;
  logic          w_accept;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;
  tag_t          w_new_tag;
  tag_t          w_head;

  // Clamp the raw configuration into the supported range
  always_comb begin
    w_ncomp = JpegComp;
    if (JpegComp == 3'd0)       w_ncomp = 3'd1;
    else if (JpegComp > MAXC_C) w_ncomp = MAXC_C;
    w_h = SubSamplingW;
    if (SubSamplingW == 2'd0)       w_h = 2'd1;
    else if (SubSamplingW > MAXS_C) w_h = MAXS_C;
    w_v = SubSamplingH;
    if (SubSamplingH == 2'd0)       w_v = 2'd1;
    else if (SubSamplingH > MAXS_C) w_v = MAXS_C;
    // A single-component (greyscale) frame has no subsampling
    if (w_ncomp == 3'd1) begin
      w_h = 2'd1;
      w_v = 2'd1;
    end
    w_mw = (McuWidth  == '0) ? XW_ONE : McuWidth;
    w_mh = (McuHeight == '0) ? XW_ONE : McuHeight;
  end

  // Latch configuration on frame start; reset falls back to a 1-block frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ncomp <= 3'd1;
      r_h     <= 2'd1;
      r_v     <= 2'd1;
      r_mw    <= XW_ONE;
      r_mh    <= XW_ONE;
    end else if (ProcessInit) begin
      r_ncomp <= w_ncomp;
      r_h     <= w_h;
      r_v     <= w_v;
      r_mw    <= w_mw;
      r_mh    <= w_mh;
    end
  end

  assign w_sub_end   = (r_subx == r_h - 2'd1) && (r_suby == r_v - 2'd1);
  assign w_comp_last = ({1'b0, r_comp} == r_ncomp - 3'd1);
  // Component 0 ends only after its whole H*V grid; other components are one block
  assign w_blk_last  = w_comp_last && ((r_comp != 2'd0) || w_sub_end);
  assign w_mx_end    = (r_mcux == r_mw - XW_ONE);
  assign w_my_end    = (r_mcuy == r_mh - XW_ONE);
  assign w_frame_end = w_blk_last && w_mx_end && w_my_end;

  assign TagValid    = (r_count != '0);
  assign BlockReady  = r_block_ready;
  assign w_accept    = BlockDone && r_block_ready && (r_state == ST_RUN);
  assign w_pop       = TagValid && TagReady;

  assign w_new_tag.comp = r_comp;
  assign w_new_tag.subx = r_subx;
  assign w_new_tag.suby = r_suby;
  assign w_new_tag.mcux = r_mcux;
  assign w_new_tag.mcuy = r_mcuy;
  assign w_new_tag.last = w_blk_last;
  assign w_new_tag.fend = w_frame_end;

  // Advance the block position on every accepted block; stop at frame end
  always_ff @(posedge clk) begin
    if (!rst || ProcessInit) begin
      r_state <= ST_RUN;
      r_comp  <= 2'd0;
      r_subx  <= 2'd0;
      r_suby  <= 2'd0;
      r_mcux  <= '0;
      r_mcuy  <= '0;
    end else if (w_accept) begin
      if ((r_comp == 2'd0) && !w_sub_end) begin
        if (r_subx == r_h - 2'd1) begin
          r_subx <= 2'd0;
          r_suby <= r_suby + 2'd1;
        end else begin
          r_subx <= r_subx + 2'd1;
        end
      end else if (!w_blk_last) begin
        r_comp <= r_comp + 2'd1;
        r_subx <= 2'd0;
        r_suby <= 2'd0;
      end else begin
        r_comp <= 2'd0;
        r_subx <= 2'd0;
        r_suby <= 2'd0;
        if (w_mx_end) begin
          r_mcux <= '0;
          r_mcuy <= w_my_end ? '0 : r_mcuy + XW_ONE;
        end else begin
          r_mcux <= r_mcux + XW_ONE;
        end
        if (w_frame_end) r_state <= ST_DONE;
      end
    end
  end

  // Next FIFO occupancy: simultaneous push and pop leaves it unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !w_pop)      w_count_nxt = r_count + CNT_ONE;
    else if (!w_accept && w_pop) w_count_nxt = r_count - CNT_ONE;
  end

  // Tag FIFO storage and pointers; BlockReady is registered from the next count
  always_ff @(posedge clk) begin
    if (!rst || ProcessInit) begin
      for (int i = 0; i < TAG_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_block_ready <= 1'b1;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_new_tag;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count       <= w_count_nxt;
      r_block_ready <= (w_count_nxt < DEPTH_C);
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign TagComp     = w_head.comp;
  assign TagSubX     = w_head.subx;
  assign TagSubY     = w_head.suby;
  assign TagMcuX     = w_head.mcux;
  assign TagMcuY     = w_head.mcuy;
  assign TagLast     = w_head.last;
  assign TagFrameEnd = w_head.fend;

  // Frame-done level and sticky overrun flag
  always_ff @(posedge clk) begin
    if (!rst || ProcessInit) begin
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_pop && w_head.fend)    r_frame_done <= 1'b1;
      if (BlockDone && !w_accept)  r_overrun    <= 1'b1;
    end
  end

  assign FrameDone    = r_frame_done;
  assign BlockOverrun = r_overrun;

endmodule

// File: tb/tb_aq_djpeg_mcu_seq.sv
// Randomised scoreboard bench for aq_djpeg_mcu_seq.
// A frame-level reference list of expected tags is built with nested loops;
// a monitor compares the FIFO head against the scoreboard whenever a tag is valid.
module tb_aq_djpeg_mcu_seq;
  localparam int XW    = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ProcessInit;
  logic [2:0]    JpegComp;
  logic [1:0]    SubSamplingW, SubSamplingH;
  logic [XW-1:0] McuWidth, McuHeight;
  logic          BlockDone;
  logic          BlockReady, TagValid, TagReady;
  logic [1:0]    TagComp, TagSubX, TagSubY;
  logic [XW-1:0] TagMcuX, TagMcuY;
  logic          TagLast, TagFrameEnd, FrameDone, BlockOverrun;

  aq_djpeg_mcu_seq #(.MAX_COMP(4), .MAX_SAMP(2), .XW(XW), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .JpegComp(JpegComp),
    .SubSamplingW(SubSamplingW), .SubSamplingH(SubSamplingH),
    .McuWidth(McuWidth), .McuHeight(McuHeight), .BlockDone(BlockDone),
    .BlockReady(BlockReady), .TagValid(TagValid), .TagReady(TagReady),
    .TagComp(TagComp), .TagSubX(TagSubX), .TagSubY(TagSubY),
    .TagMcuX(TagMcuX), .TagMcuY(TagMcuY), .TagLast(TagLast),
    .TagFrameEnd(TagFrameEnd), .FrameDone(FrameDone), .BlockOverrun(BlockOverrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int comp; int sx; int sy; int mx; int my; int last; int fend;
  } etag_t;

  etag_t exp_list[$];
  etag_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    n_tags;
  int    m_pushed, m_popped;
  bit    m_ovr, m_fd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] pack_tag(input etag_t t);
    return {2'(t.comp), 2'(t.sx), 2'(t.sy), XW'(t.mx), XW'(t.my), 1'(t.last), 1'(t.fend)};
  endfunction

  // Reference: enumerate every block of the frame in decode order
  task automatic build(input int jc, input int sw, input int sh, input int mw, input int mh);
    int n, h, v, w, ht;
    etag_t t;
    n  = (jc == 0) ? 1 : ((jc > 4) ? 4 : jc);
    h  = (sw == 0) ? 1 : ((sw > 2) ? 2 : sw);
    v  = (sh == 0) ? 1 : ((sh > 2) ? 2 : sh);
    if (n == 1) begin h = 1; v = 1; end
    w  = (mw == 0) ? 1 : mw;
    ht = (mh == 0) ? 1 : mh;
    exp_list.delete();
    for (int my = 0; my < ht; my++)
      for (int mx = 0; mx < w; mx++) begin
        for (int sy = 0; sy < v; sy++)
          for (int sx = 0; sx < h; sx++) begin
            t = '{comp:0, sx:sx, sy:sy, mx:mx, my:my, last:0, fend:0};
            exp_list.push_back(t);
          end
        for (int c = 1; c < n; c++) begin
          t = '{comp:c, sx:0, sy:0, mx:mx, my:my, last:0, fend:0};
          exp_list.push_back(t);
        end
        exp_list[exp_list.size()-1].last = 1;
      end
    exp_list[exp_list.size()-1].fend = 1;
    n_tags = exp_list.size();
  endtask

  task automatic clear_model();
    sb.delete();
    m_pushed = 0;
    m_popped = 0;
    m_ovr    = 1'b0;
    m_fd     = 1'b0;
  endtask

  // One clock of stimulus; status outputs are checked and the model advanced
  task automatic step(input bit bd, input bit rdy);
    int  mcount;
    bit  acc, pop;
    BlockDone   = bd;
    TagReady    = rdy;
    ProcessInit = 1'b0;
    @(negedge clk);
    mcount = m_pushed - m_popped;
    chk("block_ready", 64'(BlockReady), 64'(mcount < DEPTH));
    chk("tag_valid",   64'(TagValid),   64'(mcount > 0));
    chk("overrun",     64'(BlockOverrun), 64'(m_ovr));
    chk("frame_done",  64'(FrameDone),  64'(m_fd));
    acc = bd && (mcount < DEPTH) && (m_pushed < n_tags);
    pop = rdy && (mcount > 0);
    if (acc) begin
      sb.push_back(exp_list[m_pushed]);
      m_pushed++;
    end
    if (bd && !acc) m_ovr = 1'b1;
    if (pop) begin
      if (m_popped == n_tags - 1) m_fd = 1'b1;
      m_popped++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ProcessInit = 1'b0; BlockDone = 1'b0; TagReady = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_model();
    build(1, 1, 1, 1, 1);
    @(negedge clk);
    chk("rst_tag_fields", 64'({TagComp, TagSubX, TagSubY, TagMcuX, TagMcuY, TagLast, TagFrameEnd}), 64'(0));
    chk("rst_ready", 64'(BlockReady), 64'(1));
    chk("rst_valid", 64'(TagValid), 64'(0));
    chk("rst_flags", 64'({FrameDone, BlockOverrun}), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic init(input int jc, input int sw, input int sh, input int mw, input int mh);
    JpegComp     = 3'(jc);
    SubSamplingW = 2'(sw);
    SubSamplingH = 2'(sh);
    McuWidth     = XW'(mw);
    McuHeight    = XW'(mh);
    ProcessInit  = 1'b1;
    BlockDone    = 1'b0;
    TagReady     = 1'b0;
    @(posedge clk);
    #1;
    ProcessInit  = 1'b0;
    JpegComp     = 3'($urandom_range(0, 7));
    SubSamplingW = 2'($urandom_range(0, 3));
    SubSamplingH = 2'($urandom_range(0, 3));
    McuWidth     = XW'($urandom_range(0, 9));
    McuHeight    = XW'($urandom_range(0, 9));
    clear_model();
    build(jc, sw, sh, mw, mh);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  // Monitor: head tag must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && TagValid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_tag", 64'(1), 64'(0));
      end else begin
        chk("tag_head", 64'({TagComp, TagSubX, TagSubY, TagMcuX, TagMcuY, TagLast, TagFrameEnd}),
            64'(pack_tag(sb[0])));
        if (TagReady === 1'b1) void'(sb.pop_front());
      end
    end
  end

  initial begin
    int lim;
    rst = 1'b0; ProcessInit = 1'b0; BlockDone = 1'b0; TagReady = 1'b0;
    JpegComp = 3'd0; SubSamplingW = 2'd0; SubSamplingH = 2'd0;
    McuWidth = '0; McuHeight = '0;
    @(posedge clk);
    #1;
    do_reset();

    // 3 components 4:2:0, two MCUs in one row, streaming
    init(3, 2, 2, 2, 1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
    drain(3);
    chk("frame1_drained", 64'(sb.size()), 64'(0));
    // Extra block after frame end: dropped, overrun set, FrameDone held
    step(1'b1, 1'b1);
    drain(2);
    do_reset();

    // Greyscale: subsampling forced to 1x1
    init(1, 2, 2, 3, 2);
    for (int i = 0; i < 6; i++) begin step(1'b1, 1'b1); step(1'b0, 1'b1); end
    drain(2);
    chk("grey_drained", 64'(sb.size()), 64'(0));

    // Fill the FIFO with TagReady low, overrun on the fifth block, then drain
    init(3, 2, 2, 4, 4);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    drain(6);
    // Two tags held, then simultaneous push and pop
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    drain(4);

    // ProcessInit in the middle of a 4:2:0 frame
    init(3, 2, 2, 2, 2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    init(3, 2, 2, 2, 2);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    drain(3);

    // Randomised frames, some interrupted by a fresh ProcessInit
    for (int f = 0; f < 24; f++) begin
      init($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 5), $urandom_range(0, 3));
      lim = (f % 4 == 3) ? $urandom_range(2, 12) : 1500;
      for (int c = 0; c < lim && m_popped < n_tags; c++)
        step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 65);
      if (f % 4 != 3) begin
        chk("rand_drained", 64'(sb.size()), 64'(0));
        for (int c = 0; c < 3; c++) step($urandom_range(0, 1) == 1, 1'b1);
      end
      if (f % 8 == 5) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
